// File: rtl/alu_seq.sv
// Registered ALU with a persistent C/L/F/Z/N flag register and an iterative
// one-bit-per-cycle shifter. One operation in flight at a time.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic [1:0]       dbg_state
);

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];
  localparam logic [SH_W-1:0]  WIDTH_N = WIDTH[SH_W-1:0];

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [SH_W-1:0]  cnt;
  logic             sh_left;
  logic             sh_arith;

  logic             cin;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] b_mag;
  logic [SH_W-1:0]  sh_n;
  logic             is_shift;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flags;

  // Handshake: an operation is taken on a rising edge with in_valid && in_ready
  // (IDLE only); a result is released on a rising edge with out_valid && out_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    cin      = (op == OP_ADDC) ? flags[0] : 1'b0;
    add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sub_full = {1'b0, a} - {1'b0, b};
    add_ovf  = (a[M] == b[M]) && (add_full[M] != a[M]);
    sub_ovf  = (a[M] != b[M]) && (sub_full[M] != a[M]);
    // Magnitude of the signed shift amount; the most-negative value saturates too.
    b_mag    = b[M] ? (~b + 1'b1) : b;
    sh_n     = (b_mag > WIDTH_V) ? WIDTH_N : b_mag[SH_W-1:0];
    is_shift = (op == OP_LSH) || (op == OP_ASHU);
  end

  always_comb begin
    alu_res   = '0;
    alu_flags = flags;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_MOV: alu_res = b;
      OP_ADD, OP_ADDC: begin
        alu_res      = add_full[M:0];
        alu_flags[0] = add_full[WIDTH];
        alu_flags[2] = add_ovf;
      end
      OP_SUB: begin
        alu_res      = sub_full[M:0];
        alu_flags[0] = sub_full[WIDTH];
        alu_flags[2] = sub_ovf;
      end
      OP_CMP: begin
        alu_res      = sub_full[M:0];
        alu_flags[1] = (b < a);
        alu_flags[2] = sub_ovf;
        alu_flags[3] = (a == b);
        alu_flags[4] = ($signed(b) < $signed(a));
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      result   <= '0;
      flags    <= '0;
      cnt      <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift) begin
              result   <= a;
              cnt      <= sh_n;
              sh_left  <= ~b[M];
              sh_arith <= (op == OP_ASHU);
              state    <= (sh_n == '0) ? DONE : SHIFT;
            end else begin
              result <= alu_res;
              flags  <= alu_flags;
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          if (sh_left) result <= {result[M-1:0], 1'b0};
          else         result <= {sh_arith & result[M], result[M:1]};
          cnt <= cnt - 1'b1;
          if (cnt == {{(SH_W-1){1'b0}}, 1'b1}) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed and random operations checked against an
// arithmetic reference model through an expected-result queue.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;
  logic [1:0]   dbg_state;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_n = 0;
  int bp_mode = 1;  // 0 random, 1 always ready, 2 never ready
  logic seen = 1'b0;
  logic [W-1:0] held_r;
  logic [4:0]   held_f;
  logic [4:0]   mflags = 5'b0;

  logic [W-1:0] exp_q[$];
  logic [4:0]   expf_q[$];
  int           expl_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) begin
      acc_cyc <= cyc;
      acc_n   <= acc_n + 1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (bp_mode == 0)      out_ready = ($urandom_range(0, 3) != 0);
    else if (bp_mode == 1) out_ready = 1'b1;
    else                   out_ready = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: plain integer arithmetic on the operation rules
  task automatic model(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [4:0] f, output int lat);
    int ux, uy, sx, sy, s, k;
    int smax, smin;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    f = mflags; r = '0; lat = 1;
    case (o)
      8'h01: r = x & y;
      8'h02: r = x | y;
      8'h03: r = x ^ y;
      8'h0D: r = y;
      8'h05, 8'h07: begin
        k = (o == 8'h07) ? int'(mflags[0]) : 0;
        s = ux + uy + k;
        r = W'(s);
        f[0] = (s >= (1 << W));
        f[2] = ((sx + sy + k) > smax) || ((sx + sy + k) < smin);
      end
      8'h09: begin
        r = W'(ux - uy);
        f[0] = (ux < uy);
        f[2] = ((sx - sy) > smax) || ((sx - sy) < smin);
      end
      8'h0B: begin
        r = W'(ux - uy);
        f[1] = (uy < ux);
        f[2] = ((sx - sy) > smax) || ((sx - sy) < smin);
        f[3] = (ux == uy);
        f[4] = (sy < sx);
      end
      8'h84, 8'h86: begin
        k = (sy < 0) ? -sy : sy;
        if (k > W) k = W;
        lat = 1 + k;
        if (sy >= 0)        r = W'(ux << k);
        else if (o == 8'h84) r = W'(ux >> k);
        else                r = W'(sx >>> k);
      end
      default: r = '0;
    endcase
    mflags = f;
  endtask

  // driver
  task automatic issue(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic [4:0]   f;
    int           lat;
    bit           ok;
    @(negedge clk);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("issue_timeout", 32'd1, 32'd0);
    end else begin
      op = o; a = x; b = y; in_valid = 1'b1;
      model(o, x, y, r, f, lat);
      exp_q.push_back(r);
      expf_q.push_back(f);
      expl_q.push_back(lat);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            chk("result", 32'(result), 32'(exp_q.pop_front()));
            chk("flags", 32'(flags), 32'(expf_q.pop_front()));
            chk("latency", 32'(cyc - acc_cyc), 32'(expl_q.pop_front()));
          end
          held_r = result;
          held_f = flags;
        end else begin
          chk("hold_result", 32'(result), 32'(held_r));
          chk("hold_flags", 32'(flags), 32'(held_f));
        end
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
      end else begin
        seen = 1'b0;
      end
    end
  end

  logic [7:0] ops_tab [10] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h07,
                               8'h09, 8'h0B, 8'h0D, 8'h84, 8'h86};

  initial begin
    logic [7:0]   o;
    logic [W-1:0] x, y;
    int           acc0;
    bit           ok;

    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // directed
    issue(8'h05, 16'hFFFF, 16'h0001);
    issue(8'h07, 16'h0001, 16'h0001);
    issue(8'h0B, 16'h0005, 16'h0003);
    issue(8'h0B, 16'h8000, 16'h8000);
    issue(8'h84, 16'h0001, 16'd4);
    issue(8'h86, 16'h8000, 16'hFFFD);
    issue(8'h84, 16'h1234, 16'h0000);
    issue(8'h09, 16'h8000, 16'h0001);
    issue(8'h86, 16'h4321, 16'h0002);
    issue(8'h84, 16'hABCD, 16'd20);
    issue(8'h86, 16'h8001, 16'h8000);
    issue(8'h84, 16'hF00F, 16'hFFF0);
    issue(8'h55, 16'h1111, 16'h2222);
    drain();

    // backpressure with a competing request
    bp_mode = 2;
    issue(8'h02, 16'h0F0F, 16'h3000);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("bp_reach_done", 32'(ok), 32'd1);
    op = 8'h05; a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
    acc0 = acc_n;
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("bp_no_accept", 32'(acc_n), 32'(acc0));
    bp_mode = 1; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // reset during a shift
    issue(8'h84, 16'h00FF, 16'd8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete(); expf_q.delete(); expl_q.delete();
    mflags = 5'b0; seen = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("abort_recover_ready", 32'(in_ready), 32'd1);
    issue(8'h05, 16'h7FFF, 16'h0001);
    drain();

    // random traffic with random backpressure
    bp_mode = 0;
    for (int i = 0; i < 200; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : ops_tab[$urandom_range(0, 9)];
      x = W'($urandom);
      if ((o == 8'h84 || o == 8'h86) && $urandom_range(0, 3) != 0)
        y = W'($urandom_range(0, 40) - 20);
      else
        y = W'($urandom);
      issue(o, x, y);
    end
    drain();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
